// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI arbiter: state encoding, default timeout and
// the slice-offset helper used to unpack per-requester buses.
package spi_arb_pkg;

    localparam int DEFAULT_TIMEOUT = 64;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        LAUNCH    = ST_LAUNCH,
        WAIT_LOW  = ST_WAIT_LOW,
        WAIT_HIGH = ST_WAIT_HIGH,
        DONE      = ST_DONE
    } state_t;

    // Bit offset of slice idx within a packed bus of width-bit slices.
    function automatic int slice_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr+1,
// wrapping modulo NUM_REQ. Returns one-hot and binary forms of the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      pick_idx,
    output logic               found
);

    logic [IW-1:0] cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sequencer sharing one SPI master between NUM_REQ clients;
// latches the winner's word, pulses start and follows m_cs to completion.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int REG_WIDTH     = 8,
    parameter int COUNTER_WIDTH = $clog2(REG_WIDTH),
    parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
    input  logic                                 sys_clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*REG_WIDTH-1:0]         req_data,
    input  logic [NUM_REQ*(COUNTER_WIDTH+1)-1:0] req_size,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   done,
    output logic                                 err,
    output logic                                 busy,
    output logic                                 m_t_start,
    output logic [REG_WIDTH-1:0]                 m_data_in,
    output logic [COUNTER_WIDTH:0]               m_t_size,
    input  logic                                 m_cs,
    output logic [NUM_REQ-1:0]                   slv_cs
);

    // Client handshake: req[i] is a level held until done[i]. gnt[i] stays high
    // for the whole transaction; done[i] is a single-cycle pulse after m_cs has
    // gone low then high again. On timeout err pulses instead and no done fires.

    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW      = COUNTER_WIDTH + 1;
    localparam int CNT_W   = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                 state, state_nxt;
    logic [IW-1:0]          ptr, ptr_nxt;
    logic [IW-1:0]          idx, idx_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
    logic [NUM_REQ-1:0]     gnt_nxt, done_nxt;
    logic                   err_nxt, start_nxt;
    logic [REG_WIDTH-1:0]   data_nxt;
    logic [SW-1:0]          size_nxt;

    logic [NUM_REQ-1:0]     pick;
    logic [IW-1:0]          pick_idx;
    logic                   found;

    logic [REG_WIDTH-1:0]   data_arr [NUM_REQ];
    logic [SW-1:0]          size_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign data_arr[g] = req_data[slice_off(g, REG_WIDTH) +: REG_WIDTH];
        assign size_arr[g] = req_size[slice_off(g, SW) +: SW];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req      (req),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (found)
    );

    assign slv_cs  = {NUM_REQ{m_cs}} | ~gnt;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        err_nxt   = 1'b0;
        start_nxt = 1'b0;
        data_nxt  = m_data_in;
        size_nxt  = m_t_size;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = pick;
                    idx_nxt   = pick_idx;
                    data_nxt  = data_arr[pick_idx];
                    size_nxt  = size_arr[pick_idx];
                    start_nxt = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW, WAIT_HIGH: begin
                cnt_nxt = cnt_inc;
                // Progress on m_cs wins over the timeout; >= covers saturation.
                if (state == WAIT_LOW && !m_cs) begin
                    state_nxt = WAIT_HIGH;
                end else if (state == WAIT_HIGH && m_cs) begin
                    state_nxt = DONE;
                end else if (cnt >= TO_LAST) begin
                    err_nxt   = 1'b1;
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                done_nxt  = gnt;
                ptr_nxt   = idx;
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            idx       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            m_t_start <= 1'b0;
            m_data_in <= '0;
            m_t_size  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            busy      <= (state_nxt != IDLE);
            m_t_start <= start_nxt;
            m_data_in <= data_nxt;
            m_t_size  <= size_nxt;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a cycle-accurate SPI master model and a
// grant-order scoreboard.
module tb_spi_arbiter;

    localparam int NUM_REQ = 4;
    localparam int REG_WIDTH = 8;
    localparam int COUNTER_WIDTH = 3;
    localparam int TIMEOUT = 64;
    localparam int BOUND = 300;

    logic                                 sys_clk;
    logic                                 rst;
    logic [NUM_REQ-1:0]                   req;
    logic [NUM_REQ*REG_WIDTH-1:0]         req_data;
    logic [NUM_REQ*(COUNTER_WIDTH+1)-1:0] req_size;
    logic [NUM_REQ-1:0]                   gnt;
    logic [NUM_REQ-1:0]                   done;
    logic                                 err;
    logic                                 busy;
    logic                                 m_t_start;
    logic [REG_WIDTH-1:0]                 m_data_in;
    logic [COUNTER_WIDTH:0]               m_t_size;
    logic                                 m_cs;
    logic [NUM_REQ-1:0]                   slv_cs;

    int n_checks = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_err = 0;
    int n_overlap = 0;
    int n_wide = 0;
    logic start_prev = 1'b0;
    logic [NUM_REQ-1:0] exp_q[$];

    int mdl_dly = 2;
    int mdl_hold = 10;
    bit mdl_en = 1'b1;

    spi_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .REG_WIDTH     (REG_WIDTH),
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_size  (req_size),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .m_t_start (m_t_start),
        .m_data_in (m_data_in),
        .m_t_size  (m_t_size),
        .m_cs      (m_cs),
        .slv_cs    (slv_cs)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        @(negedge sys_clk);
        while (!m_t_start && n < BOUND) begin @(negedge sys_clk); n++; end
        if (!m_t_start) check({tag, "_start_timeout"}, 32'(m_t_start), 32'h1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge sys_clk);
        while (done == '0 && n < BOUND) begin @(negedge sys_clk); n++; end
        if (done == '0) check({tag, "_done_timeout"}, 32'(done), 32'hF);
    endtask

    task automatic wait_cs(input string tag, input logic level);
        int n = 0;
        @(negedge sys_clk);
        while (m_cs !== level && n < BOUND) begin @(negedge sys_clk); n++; end
        if (m_cs !== level) check({tag, "_cs_timeout"}, 32'(m_cs), 32'(level));
    endtask

    // SPI master model: m_cs falls mdl_dly cycles after start, rises mdl_hold later
    initial begin
        m_cs = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (m_t_start && mdl_en) begin
                repeat (mdl_dly) @(posedge sys_clk);
                #2 m_cs = 1'b0;
                repeat (mdl_hold) @(posedge sys_clk);
                #2 m_cs = 1'b1;
            end
        end
    end

    // scoreboard / monitor
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                if (m_t_start) begin
                    if (exp_q.size() > 0) check("grant_order", 32'(gnt), 32'(exp_q.pop_front()));
                    else check("grant_unexpected", 32'(gnt), 32'h0);
                end
                if (!$onehot0(gnt)) n_overlap++;
                if (m_t_start && start_prev) n_wide++;
                n_done += $countones(done);
                if (err) n_err++;
            end
            start_prev = m_t_start;
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        req = '0;
        req_data = '0;
        req_size = '0;

        // reset values
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_start", 32'(m_t_start), 32'h0);
        check("rst_data", 32'(m_data_in), 32'h0);
        check("rst_size", 32'(m_t_size), 32'h0);
        check("rst_slv_cs", 32'(slv_cs), 32'hF);

        // single request from requester 1
        req_data = 32'h0000_A500;
        req_size = 16'h0080;
        exp_q.push_back(4'b0010);
        req = 4'b0010;
        wait_start("t1");
        check("t1_data", 32'(m_data_in), 32'hA5);
        check("t1_size", 32'(m_t_size), 32'h8);
        check("t1_busy", 32'(busy), 32'h1);
        @(negedge sys_clk);
        check("t1_start_width", 32'(m_t_start), 32'h0);
        wait_cs("t1", 1'b0);
        check("t1_slv_cs", 32'(slv_cs), 32'hD);
        check("t1_gnt_held", 32'(gnt), 32'h2);
        wait_done("t1");
        check("t1_done", 32'(done), 32'h2);
        check("t1_gnt_clr", 32'(gnt), 32'h0);
        check("t1_busy_idle", 32'(busy), 32'h0);
        req = '0;
        @(negedge sys_clk);
        check("t1_done_pulse", 32'(done), 32'h0);

        // all four contend, each drops after its done
        do_reset();
        req_data = 32'h4433_2211;
        req_size = 16'h5678;
        for (int i = 0; i < NUM_REQ; i++) exp_q.push_back(4'(1 << i));
        req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_start("t2");
            check("t2_data", 32'(m_data_in), 32'(8'h11 * (i + 1)));
            check("t2_size", 32'(m_t_size), 32'(8 - i));
            wait_done("t2");
            check("t2_done", 32'(done), 32'(1 << i));
            req = req & ~done;
        end

        // fairness: two requesters held for four transactions
        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            wait_start("t3");
            check("t3_data", 32'(m_data_in), (i % 2 == 0) ? 32'h11 : 32'h22);
            wait_done("t3");
            check("t3_done", 32'(done), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        req = '0;

        // timeout: master never drops m_cs; requester 1 must retry first
        do_reset();
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        mdl_en = 1'b0;
        req = 4'b0110;
        wait_start("t4");
        n = 0;
        do begin @(negedge sys_clk); n++; end while (!err && n < 200);
        check("t4_err_latency", 32'(n), 32'(TIMEOUT + 1));
        check("t4_gnt_clr", 32'(gnt), 32'h0);
        check("t4_no_done", 32'(done), 32'h0);
        mdl_en = 1'b1;
        wait_start("t4_retry");
        check("t4_err_pulse", 32'(err), 32'h0);
        wait_done("t4");
        check("t4_done", 32'(done), 32'h2);
        req = '0;

        // reset during WAIT_HIGH; pointer must return to its reset value
        exp_q.push_back(4'b0100);
        req = 4'b0100;
        wait_start("t5");
        wait_cs("t5", 1'b0);
        repeat (3) @(negedge sys_clk);
        rst = 1'b1;
        req = '0;
        @(negedge sys_clk);
        check("t5_gnt", 32'(gnt), 32'h0);
        check("t5_slv_cs", 32'(slv_cs), 32'hF);
        check("t5_start", 32'(m_t_start), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        wait_cs("t5", 1'b1);
        exp_q.push_back(4'b0001);
        req = 4'b0101;
        wait_start("t5_after");
        wait_done("t5");
        check("t5_done", 32'(done), 32'h1);
        req = '0;

        // late data change after grant is ignored
        req_data = 32'h0000_5A00;
        req_size = 16'h0050;
        exp_q.push_back(4'b0010);
        req = 4'b0010;
        wait_start("t6");
        check("t6_data_lat", 32'(m_data_in), 32'h5A);
        req_data = '1;
        req_size = '1;
        wait_cs("t6", 1'b0);
        check("t6_data_mid", 32'(m_data_in), 32'h5A);
        check("t6_size_mid", 32'(m_t_size), 32'h5);
        wait_done("t6");
        check("t6_data_end", 32'(m_data_in), 32'h5A);
        req = '0;

        // final report
        repeat (3) @(negedge sys_clk);
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        check("gnt_overlap", 32'(n_overlap), 32'h0);
        check("start_wide", 32'(n_wide), 32'h0);
        check("done_total", 32'(n_done), 32'd12);
        check("err_total", 32'(n_err), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
